// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller.
//   IMEM_AW / IMEM_DW / IMEM_DEPTH : default address width, data width, implemented words
//   imemState_t : controller state (IDLE, LOCK)
//   reqId_t     : requester identity used by the round-robin arbiter
package imem_ctrl_pkg;

  localparam int unsigned IMEM_AW    = 14;
  localparam int unsigned IMEM_DW    = 19;
  localparam int unsigned IMEM_DEPTH = 256;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } imemState_t;

  typedef enum logic {
    REQ_LD = 1'b0,
    REQ_FE = 1'b1
  } reqId_t;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin grant logic (loader vs. fetch) with a last-grant flop.
// Only present when IMEM_ACCESS_RR_EN is defined; the default build uses fixed
// loader priority inline in imem_access_ctrl.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : arbitration enabled (controller in IDLE)
//   ldReq      : loader request
//   feReq      : fetch request
//   ldGnt      : loader granted (combinational)
//   feGnt      : fetch granted (combinational)
`ifdef IMEM_ACCESS_RR_EN
module imem_rr_arb
  import imem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ldReq,
  input  logic feReq,
  output logic ldGnt,
  output logic feGnt
);

  reqId_t lastGnt;

  // On contention the requester not granted last time wins.
  always_comb begin
    ldGnt = 1'b0;
    feGnt = 1'b0;
    if (en) begin
      if (ldReq && feReq) begin
        if (lastGnt == REQ_LD) feGnt = 1'b1;
        else                   ldGnt = 1'b1;
      end else begin
        ldGnt = ldReq;
        feGnt = feReq;
      end
    end
  end

  // Reset to REQ_FE so the loader wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n)     lastGnt <= REQ_FE;
    else if (ldGnt) lastGnt <= REQ_LD;
    else if (feGnt) lastGnt <= REQ_FE;
  end

endmodule
`endif

// File: rtl/imem_access_ctrl.sv
// Arbiter/sequencer sharing the single instruction-memory port between the boot
// loader (writes) and instruction fetch (reads). Winning request is registered onto
// we_IM/addIM/dataIM; reads return via fe_rvalid/fe_rdata two cycles after accept.
// Loader bursts (ld_last=0) lock out fetch until the word with ld_last=1.
// Out-of-range requests (addr >= DEPTH) are accepted, not issued, and flagged on oob_err.
// Configuration macro: IMEM_ACCESS_RR_EN -> round-robin in IDLE (else loader priority).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last : loader write request
//   fe_valid/fe_ready/fe_addr       : fetch read request
//   fe_rvalid/fe_rdata              : fetch read response
//   oob_err                         : out-of-range request pulse
//   we_IM/addIM/dataIM              : memory command (registered)
//   outIM                           : memory read data
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned AW    = IMEM_AW,
  parameter int unsigned DW    = IMEM_DW,
  parameter int unsigned DEPTH = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          fe_valid,
  output logic          fe_ready,
  input  logic [AW-1:0] fe_addr,
  output logic          fe_rvalid,
  output logic [DW-1:0] fe_rdata,
  output logic          oob_err,
  output logic          we_IM,
  output logic [AW-1:0] addIM,
  output logic [DW-1:0] dataIM,
  input  logic [DW-1:0] outIM
);

  imemState_t    state;
  logic          isLock;
  logic          arbLd;
  logic          arbFe;
  logic          ldGnt;
  logic          feGnt;
  logic          ldInRange;
  logic          feInRange;
  logic          rdPend;     // read issued to memory this cycle
  logic          rdPendOob;  // that read was out of range
  logic          rvOob;      // current response belongs to an out-of-range read
  logic [DW-1:0] rdataQ;     // last delivered read data

  assign isLock = (state == LOCK);

`ifdef IMEM_ACCESS_RR_EN
  imem_rr_arb uArb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~isLock),
    .ldReq (ld_valid),
    .feReq (fe_valid),
    .ldGnt (arbLd),
    .feGnt (arbFe)
  );
`else
  assign arbLd = ld_valid;
  assign arbFe = fe_valid & ~ld_valid;
`endif

  // LOCK bypasses arbitration: only the loader may proceed. Reset masks both readies.
  assign ldGnt    = rst_n & ld_valid & (isLock | arbLd);
  assign feGnt    = rst_n & ~isLock & arbFe;
  assign ld_ready = ldGnt;
  assign fe_ready = feGnt;

  assign ldInRange = (ld_addr < AW'(DEPTH));
  assign feInRange = (fe_addr < AW'(DEPTH));

  // Command issue, read-latency pipeline and burst-lock state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_IM     <= 1'b0;
      addIM     <= '0;
      dataIM    <= '0;
      oob_err   <= 1'b0;
      rdPend    <= 1'b0;
      rdPendOob <= 1'b0;
      fe_rvalid <= 1'b0;
      rvOob     <= 1'b0;
      rdataQ    <= '0;
    end else begin
      we_IM     <= 1'b0;
      oob_err   <= 1'b0;
      rdPend    <= feGnt;
      rdPendOob <= feGnt & ~feInRange;
      fe_rvalid <= rdPend;
      rvOob     <= rdPendOob;
      if (fe_rvalid) rdataQ <= fe_rdata;

      if (ldGnt) begin
        if (ldInRange) begin
          we_IM  <= 1'b1;
          addIM  <= ld_addr;
          dataIM <= ld_data;
        end else begin
          oob_err <= 1'b1;
        end
      end else if (feGnt) begin
        if (feInRange) addIM   <= fe_addr;
        else           oob_err <= 1'b1;
      end

      case (state)
        IDLE:    if (ldGnt && !ld_last) state <= LOCK;
        LOCK:    if (ldGnt && ld_last)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory data is already registered, so the response passes straight through
  // in its valid cycle and is held afterwards.
  assign fe_rdata = fe_rvalid ? (rvOob ? '0 : outIM) : rdataQ;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_imem_access_ctrl;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 19;
  localparam int unsigned DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          fe_valid;
  logic          fe_ready;
  logic [AW-1:0] fe_addr;
  logic          fe_rvalid;
  logic [DW-1:0] fe_rdata;
  logic          oob_err;
  logic          we_IM;
  logic [AW-1:0] addIM;
  logic [DW-1:0] dataIM;
  logic [DW-1:0] outIM;

  imem_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .fe_valid  (fe_valid),
    .fe_ready  (fe_ready),
    .fe_addr   (fe_addr),
    .fe_rvalid (fe_rvalid),
    .fe_rdata  (fe_rdata),
    .oob_err   (oob_err),
    .we_IM     (we_IM),
    .addIM     (addIM),
    .dataIM    (dataIM),
    .outIM     (outIM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the controller: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (we_IM) mem[addIM[7:0]] <= dataIM;
    outIM <= mem[addIM[7:0]];
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents in accept order plus expected port values.
  logic [DW-1:0] refMem [DEPTH];
  logic          eWe, eOob, eRv, pRv, lock, lastLd;
  logic [AW-1:0] eAdd;
  logic [DW-1:0] eData, eRd, pRd;
  int            rvCount;

  task automatic modelReset();
    eWe = 0; eOob = 0; eRv = 0; pRv = 0; lock = 0; lastLd = 0;
    eAdd = '0; eData = '0; eRd = '0; pRd = '0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
  task automatic cyc(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                     input logic ll, input logic fv, input logic [AW-1:0] fa, input logic rn);
    logic gL, gF, nRv;
    logic [DW-1:0] nRd;
    @(negedge clk);
    checkEq("we_IM", 32'(we_IM), 32'(eWe));
    checkEq("addIM", 32'(addIM), 32'(eAdd));
    checkEq("dataIM", 32'(dataIM), 32'(eData));
    checkEq("oob_err", 32'(oob_err), 32'(eOob));
    checkEq("fe_rvalid", 32'(fe_rvalid), 32'(eRv));
    checkEq("fe_rdata", 32'(fe_rdata), 32'(eRd));
    if (fe_rvalid) rvCount++;
    ld_valid = lv; ld_addr = la; ld_data = ldd; ld_last = ll;
    fe_valid = fv; fe_addr = fa; rst_n = rn;
    #1;
    gL = 0; gF = 0;
    if (rn) begin
      if (lock) begin
        gL = lv;
      end else begin
`ifdef IMEM_ACCESS_RR_EN
        if (lv && fv) begin gL = !lastLd; gF = lastLd; end
        else begin gL = lv; gF = fv; end
`else
        gL = lv; gF = fv && !lv;
`endif
      end
    end
    checkEq("ld_ready", 32'(ld_ready), 32'(gL));
    checkEq("fe_ready", 32'(fe_ready), 32'(gF));
    if (!rn) begin
      modelReset();
    end else begin
      nRv = pRv;
      nRd = pRv ? pRd : eRd;
      eWe = 0; eOob = 0; pRv = 0;
      if (gL) begin
        if (32'(la) < DEPTH) begin
          eWe = 1; eAdd = la; eData = ldd; refMem[la[7:0]] = ldd;
        end else eOob = 1;
        if (!lock) lastLd = 1;
        lock = !ll;
      end
      if (gF) begin
        pRv = 1;
        if (32'(fa) < DEPTH) begin eAdd = fa; pRd = refMem[fa[7:0]]; end
        else begin eOob = 1; pRd = '0; end
        lastLd = 0;
      end
      eRv = nRv; eRd = nRd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] a;
    int rvStart;
    rst_n = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 1;
    fe_valid = 0; fe_addr = '0;
    rvCount = 0;
    modelReset();
    for (int i = 0; i < int'(DEPTH); i++) refMem[i] = '0;
    repeat (3) @(posedge clk);

    // Preload every word through the loader.
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(1'b1, AW'(i), DW'($urandom), 1'b1, 1'b0, '0, 1'b1);
    idle(2);

    // Write then read the same address.
    cyc(1'b1, 14'h005, 19'h7ABCD, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h005, 1'b1);
    idle(3);
    checkEq("wr_rd_data", 32'(fe_rdata), 32'h7ABCD);

    // Contention in IDLE.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, AW'(8'h20 + i), DW'($urandom), 1'b1, 1'b1, AW'(8'h30 + i), 1'b1);
    idle(3);

    // Locked burst with fetch held.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, AW'(8'h10 + i), DW'($urandom), (i == 3), 1'b1, 14'h001, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h001, 1'b1);
    idle(3);

    // Out-of-range read.
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h0100, 1'b1);
    idle(3);

    // Streaming reads.
    rvStart = rvCount;
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b1, 1'b1, AW'(i), 1'b1);
    idle(3);
    checkEq("stream_rvalid_count", 32'(rvCount - rvStart), 32'd8);

    // Reset with a read in flight, then reset while locked.
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h003, 1'b1);
    cyc(1'b1, 14'h040, 19'h12345, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    cyc(1'b1, 14'h041, 19'h00111, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 14'h042, 19'h00222, 1'b0, 1'b1, 14'h002, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h002, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 14'h002, 1'b1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic lv, fv, ll, rn;
      logic [AW-1:0] fa;
      lv = 1'($urandom_range(0, 1));
      fv = 1'($urandom_range(0, 1));
      ll = ($urandom_range(0, 9) < 7);
      rn = ($urandom_range(0, 99) != 0);
      a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 16383)) : AW'($urandom_range(0, 255));
      fa = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 16383)) : AW'($urandom_range(0, 255));
      cyc(lv, a, DW'($urandom), ll, fv, fa, rn);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
